// File: rtl/display_timing_720p.sv
// Free-running 1280x720@60 video timing generator. Blanking maps to negative coordinates so the
// active picture always starts at (0,0); every output is registered and aligned with o_sx/o_sy.
module display_timing_720p #(
  parameter int   H_RES  = 1280,
  parameter int   H_FP   = 110,
  parameter int   H_SYNC = 40,
  parameter int   H_BP   = 220,
  parameter int   V_RES  = 720,
  parameter int   V_FP   = 5,
  parameter int   V_SYNC = 5,
  parameter int   V_BP   = 20,
  parameter logic H_POL  = 1'b1,
  parameter logic V_POL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  output logic signed [15:0] o_sx,
  output logic signed [15:0] o_sy,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_line,
  output logic               o_frame,
  output logic        [15:0] o_frame_cnt
);

  localparam int HStaI  = -(H_FP + H_SYNC + H_BP);
  localparam int HsStaI = HStaI + H_FP;
  localparam int HsEndI = HsStaI + H_SYNC;
  localparam int HaEndI = H_RES - 1;
  localparam int VStaI  = -(V_FP + V_SYNC + V_BP);
  localparam int VsStaI = VStaI + V_FP;
  localparam int VsEndI = VsStaI + V_SYNC;
  localparam int VaEndI = V_RES - 1;

  localparam logic signed [15:0] H_STA  = 16'(HStaI);
  localparam logic signed [15:0] HS_STA = 16'(HsStaI);
  localparam logic signed [15:0] HS_END = 16'(HsEndI);
  localparam logic signed [15:0] HA_END = 16'(HaEndI);
  localparam logic signed [15:0] V_STA  = 16'(VStaI);
  localparam logic signed [15:0] VS_STA = 16'(VsStaI);
  localparam logic signed [15:0] VS_END = 16'(VsEndI);
  localparam logic signed [15:0] VA_END = 16'(VaEndI);

  logic signed [15:0] sx_q, sx_d;
  logic signed [15:0] sy_q, sy_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic               line_q, line_d;
  logic               frame_q, frame_d;
  logic        [15:0] frame_cnt_q, frame_cnt_d;

  // Decodes look at the next coordinate so registered outputs line up with registered counters.
  always_comb begin
    sx_d = sx_q + 16'sd1;
    sy_d = sy_q;
    if (sx_q == HA_END) begin
      sx_d = H_STA;
      sy_d = (sy_q == VA_END) ? V_STA : sy_q + 16'sd1;
    end
    hs_d        = (sx_d >= HS_STA && sx_d < HS_END) ? H_POL : ~H_POL;
    vs_d        = (sy_d >= VS_STA && sy_d < VS_END) ? V_POL : ~V_POL;
    de_d        = !sx_d[15] && !sy_d[15];
    line_d      = (sx_d == H_STA);
    frame_d     = line_d && (sy_d == V_STA);
    frame_cnt_d = frame_cnt_q + {15'd0, frame_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q        <= H_STA;
      sy_q        <= V_STA;
      hs_q        <= ~H_POL;
      vs_q        <= ~V_POL;
      de_q        <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_sx        = sx_q;
  assign o_sy        = sy_q;
  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_de        = de_q;
  assign o_line      = line_q;
  assign o_frame     = frame_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
